mandel_iter_engine: RTL and testbench
=====================================

MANDEL_ITER_ENGINE -- requirements
Module: mandel_iter_engine

Interface
REQ-001 SHALL have parameter W, default 32: signed fixed-point word width of coordinates.
REQ-002 SHALL have parameter FRAC, default 28: fraction bits, giving Q4.28 with range [-8, 8).
REQ-003 SHALL have parameter MAX_ITER, default 1000: iteration limit.
REQ-004 SHALL have parameter TAG_W, default 16: width of the opaque pixel tag.
REQ-005 sync_clk  in  1  sole clock; all logic on posedge.
REQ-006 sync_rst  in  1  synchronous, active-high reset.
REQ-007 flush  in  1  synchronous abort of any job in flight.
REQ-008 in_valid  in  1  pixel request valid.
REQ-009 in_ready  out  1  engine able to accept a request.
REQ-010 c_re  in  W  signed real part of c.
REQ-011 c_im  in  W  signed imaginary part of c.
REQ-012 in_tag  in  TAG_W  pixel tag, returned unchanged with the result.
REQ-013 out_valid  out  1  result valid.
REQ-014 out_ready  in  1  downstream (pixel draw/colour stage) accepts the result.
REQ-015 out_count  out  16  iteration count.
REQ-016 out_tag  out  TAG_W  tag of the job.

Function
REQ-017 SHALL implement an FSM with states IDLE, ITER and DONE.
REQ-018 in_ready SHALL equal (state==IDLE); a request SHALL be accepted on an edge with in_valid&&in_ready, latching c_re, c_im and in_tag, clearing re, im and i to 0, and entering ITER.
REQ-019 Each ITER cycle SHALL perform exactly one iteration:
- xsq=re*re and ysq=im*im as full 2W-bit signed products.
- escape if (xsq+ysq) > (4<<(2*FRAC)), compared at 2W+1 bits with no truncation; a magnitude of exactly 4 SHALL NOT escape.
REQ-020 On escape at index i, the engine SHALL load out_count=i, enter DONE, and SHALL NOT update z.
REQ-021 Otherwise it SHALL update:
- re <= ((xsq-ysq)>>>FRAC)+c_re
- im <= ((2*re*im)>>>FRAC)+c_im
- i <= i+1
Shifts SHALL be arithmetic (floor); results SHALL be truncated to W bits with two's-complement wrap.
REQ-022 If index MAX_ITER-1 does not escape, the engine SHALL enter DONE with out_count=1 (in-set marker, equal to the draw stage minlimit).
REQ-023 Latency SHALL be k+1 cycles from the accept edge to out_valid for escape at index k, and MAX_ITER cycles for a non-escaping pixel.
REQ-024 out_valid SHALL equal (state==DONE); out_count and out_tag SHALL hold stable while out_valid&&!out_ready.
REQ-025 On out_valid&&out_ready the engine SHALL return to IDLE; in_ready SHALL rise the following cycle, with no same-cycle bypass.
REQ-026 flush SHALL force IDLE on the next edge from any state, dropping the job with no result emitted; flush SHALL override a simultaneous accept or output handshake.
REQ-027 c inputs SHALL be sampled only at accept; changes to them during ITER or DONE SHALL have no effect.

Reset
REQ-028 sync_rst SHALL have priority over flush and handshakes.
REQ-029 sync_rst SHALL force state=IDLE, out_valid=0, out_count=0, out_tag=0, re=im=0 and i=0; in_ready SHALL be 1 in the cycle after reset.
REQ-030 Reset during ITER or DONE SHALL discard the job with no result emitted.

Verification
REQ-031 c=(0x2000_0000,0) (2.0+0i) -> out_count=2, out_valid 3 cycles after accept; exactly-4 boundary not escaped at i=1.
REQ-032 c=(0x1000_0000,0x1000_0000) (1+1i) -> out_count=2 after 3 cycles; c=(0xE000_0000,0) (-2.0, fixed point) -> out_count=1 after MAX_ITER cycles.
REQ-033 c=0, MAX_ITER=16 -> out_count=1 with out_valid exactly 16 cycles after accept; in_ready low throughout.
REQ-034 out_ready held low 5 cycles in DONE with tag 0x00A5 -> out_valid, out_count and out_tag stable; in_ready rises the cycle after the handshake.
REQ-035 sync_rst or flush asserted at iteration 5 of a c=0 job -> no result emitted; next job c=2.0 returns out_count=2 with its own tag.
REQ-036 Back-to-back: 200 random jobs checked against a real-arithmetic model run with identical Q4.28 truncation; count and tag order SHALL match.

Source files
------------

// File: rtl/mandel_iter_engine.sv
// ============================================================================
// mandel_iter_engine : one-iteration-per-cycle Mandelbrot escape-count engine
// Rev 1.0
// ============================================================================
`default_nettype none

module mandel_iter_engine #(
  parameter int W        = 32,
  parameter int FRAC     = 28,
  parameter int MAX_ITER = 1000,
  parameter int TAG_W    = 16
) (
  input  logic                    sync_clk,
  input  logic                    sync_rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [W-1:0]     c_re,
  input  logic signed [W-1:0]     c_im,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [15:0]             out_count,
  output logic [TAG_W-1:0]        out_tag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2*W:0] c_LIMIT = (2*W+1)'(4) << (2*FRAC);
  localparam logic [15:0]  c_LAST  = 16'(MAX_ITER - 1);

  state_t                r_state;
  logic signed [W-1:0]   r_re;
  logic signed [W-1:0]   r_im;
  logic signed [W-1:0]   r_c_re;
  logic signed [W-1:0]   r_c_im;
  logic [15:0]           r_iter;
  logic                  r_in_ready;
  logic                  r_out_valid;
  logic [15:0]           r_out_count;
  logic [TAG_W-1:0]      r_out_tag;

  logic signed [2*W-1:0] w_re_ext;
  logic signed [2*W-1:0] w_im_ext;
  logic signed [2*W-1:0] w_xsq;
  logic signed [2*W-1:0] w_ysq;
  logic signed [2*W-1:0] w_xy;
  logic [2*W:0]          w_mag;
  logic signed [2*W:0]   w_diff;
  logic signed [2*W:0]   w_xy2;
  logic signed [W-1:0]   w_re_next;
  logic signed [W-1:0]   w_im_next;
  logic                  w_escape;

  // Squares are non-negative, so the magnitude sum is compared unsigned at 2W+1 bits.
  assign w_re_ext  = (2*W)'(r_re);
  assign w_im_ext  = (2*W)'(r_im);
  assign w_xsq     = w_re_ext * w_re_ext;
  assign w_ysq     = w_im_ext * w_im_ext;
  assign w_xy      = w_re_ext * w_im_ext;
  assign w_mag     = {1'b0, w_xsq} + {1'b0, w_ysq};
  assign w_escape  = (w_mag > c_LIMIT);
  assign w_diff    = (2*W+1)'(w_xsq) - (2*W+1)'(w_ysq);
  assign w_xy2     = (2*W+1)'(w_xy) <<< 1;
  assign w_re_next = W'(w_diff >>> FRAC) + r_c_re;
  assign w_im_next = W'(w_xy2 >>> FRAC) + r_c_im;

  always_ff @(posedge sync_clk) begin
    if (sync_rst) begin
      r_state     <= S_IDLE;
      r_re        <= '0;
      r_im        <= '0;
      r_c_re      <= '0;
      r_c_im      <= '0;
      r_iter      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_count <= '0;
      r_out_tag   <= '0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_c_re     <= c_re;
            r_c_im     <= c_im;
            r_out_tag  <= in_tag;
            r_re       <= '0;
            r_im       <= '0;
            r_iter     <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ITER;
          end
        end
        S_ITER: begin
          if (w_escape) begin
            r_out_count <= r_iter;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (r_iter == c_LAST) begin
            // Non-escaping pixels report 1, the draw stage's in-set marker.
            r_out_count <= 16'd1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_re   <= w_re_next;
            r_im   <= w_im_next;
            r_iter <= r_iter + 16'd1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_count = r_out_count;
  assign out_tag   = r_out_tag;

endmodule

`default_nettype wire

// File: tb/tb_mandel_iter_engine.sv
// ============================================================================
// tb_mandel_iter_engine : directed and random checks of the iteration engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mandel_iter_engine;

  localparam int SMALL_ITER = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic               iv_a, iv_b, or_a, or_b;
  logic signed [31:0] c_re, c_im;
  logic [15:0]        in_tag;
  logic               ir_a, ov_a, ir_b, ov_b;
  logic [15:0]        cnt_a, tag_a, cnt_b, tag_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mandel_iter_engine #(.W(32), .FRAC(28), .MAX_ITER(SMALL_ITER), .TAG_W(16)) dut_a (
    .sync_clk(clk), .sync_rst(rst), .flush(flush),
    .in_valid(iv_a), .in_ready(ir_a), .c_re(c_re), .c_im(c_im), .in_tag(in_tag),
    .out_valid(ov_a), .out_ready(or_a), .out_count(cnt_a), .out_tag(tag_a)
  );

  mandel_iter_engine dut_b (
    .sync_clk(clk), .sync_rst(rst), .flush(flush),
    .in_valid(iv_b), .in_ready(ir_b), .c_re(c_re), .c_im(c_im), .in_tag(in_tag),
    .out_valid(ov_b), .out_ready(or_b), .out_count(cnt_b), .out_tag(tag_b)
  );

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Q4.28 reference with floor shifts and 32-bit wrap on every update.
  task automatic model(input logic signed [31:0] cr, input logic signed [31:0] ci,
                       input int maxit, output int cnt, output bit esc);
    logic signed [31:0] re, im, rn;
    logic signed [67:0] a, b, xs, ys, p, t;
    re = 0; im = 0; cnt = 1; esc = 1'b0;
    for (int k = 0; k < maxit; k++) begin
      a = re; b = im;
      xs = a * a; ys = b * b; p = a * b;
      if (xs + ys > (68'sd4 <<< 56)) begin
        cnt = k; esc = 1'b1;
        return;
      end
      t  = (xs - ys) >>> 28;
      rn = t[31:0] + cr;
      t  = (2 * p) >>> 28;
      im = t[31:0] + ci;
      re = rn;
    end
  endtask

  task automatic run_job(input bit sel, input logic [31:0] cr, input logic [31:0] ci,
                         input logic [15:0] tg, input int hold,
                         output logic [15:0] cnt, output logic [15:0] otag, output int lat,
                         output bit rdy_seen, output bit unstable);
    c_re = cr; c_im = ci; in_tag = tg;
    if (sel) iv_b = 1'b1; else iv_a = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0; iv_b = 1'b0;
    c_re = $urandom; c_im = $urandom; in_tag = 16'($urandom);
    lat = 0; rdy_seen = 1'b0; unstable = 1'b0;
    while (!(sel ? ov_b : ov_a) && lat < 2000) begin
      if (sel ? ir_b : ir_a) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    cnt  = sel ? cnt_b : cnt_a;
    otag = sel ? tag_b : tag_a;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (!(sel ? ov_b : ov_a) || (sel ? cnt_b : cnt_a) !== cnt || (sel ? tag_b : tag_a) !== otag)
        unstable = 1'b1;
    end
    if (sel ? ir_b : ir_a) rdy_seen = 1'b1;
    if (sel) or_b = 1'b1; else or_a = 1'b1;
    @(posedge clk); #1;
    or_a = 1'b0; or_b = 1'b0;
  endtask

  logic [15:0] r_cnt, r_tag;
  int          lat, exp_cnt;
  bit          rdy_seen, unstable, exp_esc, seen_ov;
  logic [31:0] cr, ci;
  logic [15:0] tg;

  initial begin
    rst = 1'b1; flush = 1'b0; iv_a = 1'b0; iv_b = 1'b0; or_a = 1'b0; or_b = 1'b0;
    c_re = '0; c_im = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready", 64'(ir_a), 64'd1);
    check("reset_out_valid", 64'(ov_a), 64'd0);
    check("reset_out_count", 64'(cnt_a), 64'd0);
    check("reset_out_tag", 64'(tag_a), 64'd0);

    // c = 2.0: |z|^2 hits exactly 4 at i=1 and must not escape there.
    run_job(1'b0, 32'h2000_0000, 32'h0, 16'h0011, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
    check("c2_count", 64'(r_cnt), 64'd2);
    check("c2_latency", 64'(lat), 64'd3);
    check("c2_tag", 64'(r_tag), 64'h0011);
    check("c2_in_ready_after", 64'(ir_a), 64'd1);
    check("c2_out_valid_after", 64'(ov_a), 64'd0);

    run_job(1'b0, 32'h1000_0000, 32'h1000_0000, 16'h0022, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
    check("c1p1i_count", 64'(r_cnt), 64'd2);
    check("c1p1i_latency", 64'(lat), 64'd3);

    run_job(1'b1, 32'hE000_0000, 32'h0, 16'h0033, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
    check("cm2_count", 64'(r_cnt), 64'd1);
    check("cm2_latency", 64'(lat), 64'd1000);
    check("cm2_tag", 64'(r_tag), 64'h0033);

    run_job(1'b0, 32'h0, 32'h0, 16'h0044, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
    check("c0_count", 64'(r_cnt), 64'd1);
    check("c0_latency", 64'(lat), 64'(SMALL_ITER));
    check("c0_in_ready_low", 64'(rdy_seen), 64'd0);

    run_job(1'b0, 32'h2000_0000, 32'h0, 16'h00A5, 5, r_cnt, r_tag, lat, rdy_seen, unstable);
    check("hold_stable", 64'(unstable), 64'd0);
    check("hold_count", 64'(r_cnt), 64'd2);
    check("hold_tag", 64'(r_tag), 64'h00A5);
    check("hold_no_bypass", 64'(rdy_seen), 64'd0);
    check("hold_in_ready_after", 64'(ir_a), 64'd1);

    // Abort a c=0 job at iteration 5, first with flush then with reset.
    for (int m = 0; m < 2; m++) begin
      c_re = '0; c_im = '0; in_tag = 16'h0BAD; iv_a = 1'b1;
      @(posedge clk); #1;
      iv_a = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      if (m == 0) flush = 1'b1; else rst = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; rst = 1'b0;
      check(m == 0 ? "flush_in_ready" : "rst_in_ready", 64'(ir_a), 64'd1);
      seen_ov = 1'b0;
      for (int w = 0; w < 20; w++) begin
        if (ov_a) seen_ov = 1'b1;
        @(posedge clk); #1;
      end
      check(m == 0 ? "flush_no_result" : "rst_no_result", 64'(seen_ov), 64'd0);
      tg = (m == 0) ? 16'h0222 : 16'h0333;
      run_job(1'b0, 32'h2000_0000, 32'h0, tg, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
      check(m == 0 ? "flush_next_count" : "rst_next_count", 64'(r_cnt), 64'd2);
      check(m == 0 ? "flush_next_tag" : "rst_next_tag", 64'(r_tag), 64'(tg));
    end

    // Flush must win over a simultaneous accept.
    c_re = 32'h2000_0000; c_im = '0; in_tag = 16'h0444; iv_a = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    iv_a = 1'b0; flush = 1'b0;
    check("flush_vs_accept_idle", 64'(ir_a), 64'd1);
    seen_ov = 1'b0;
    for (int w = 0; w < 6; w++) begin
      if (ov_a) seen_ov = 1'b1;
      @(posedge clk); #1;
    end
    check("flush_vs_accept_no_result", 64'(seen_ov), 64'd0);

    for (int n = 0; n < 200; n++) begin
      if (n % 8 == 7) begin
        cr = $urandom; ci = $urandom;
      end else begin
        cr = 32'($urandom_range(0, 32'h4000_0000)) - 32'h2800_0000;
        ci = 32'($urandom_range(0, 32'h3000_0000)) - 32'h1800_0000;
      end
      tg = 16'(n + 16'h1000);
      model(cr, ci, SMALL_ITER, exp_cnt, exp_esc);
      run_job(1'b0, cr, ci, tg, 0, r_cnt, r_tag, lat, rdy_seen, unstable);
      check("rand_count", 64'(r_cnt), 64'(exp_cnt));
      check("rand_tag", 64'(r_tag), 64'(tg));
      check("rand_latency", 64'(lat), exp_esc ? 64'(exp_cnt + 1) : 64'(SMALL_ITER));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
